oflow_core_fsm_top: RTL

- Frame-level sequencer of the oflow core; sits directly upstream of the FE and registration FSMs.
- Latches the frame's bbox count and splits it into sets of PE_NUM.
- Drives start_pe, new_set, num_of_sets and counter_of_remain_bboxes, and tracks done_fe / done_registration per set.
- Allows at most one set in registration while the next set is in FE, then pulses done_frame.

---
 rtl/oflow_core_fsm_top_pkg.sv | 26 ++
 rtl/oflow_core_pe_mask_gen.sv | 16 +
 rtl/oflow_core_fsm_top.sv | 130 +++++++++++++
 3 files changed

// File: rtl/oflow_core_fsm_top_pkg.sv
// Shared oflow core constants, the frame sequencer state type and the
// bbox-count to set-count helper.
package oflow_core_define;

  localparam int unsigned PE_NUM          = 24;
  localparam int unsigned SET_LEN         = 6;
  localparam int unsigned REMAIN_BBOX_LEN = 10;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StNewSet,
    StWaitFe,
    StHold,
    StWaitReg,
    StDone
  } oflow_core_top_state_t;

  // ceil(n / PE_NUM); the divisor is a constant, so this folds to fixed logic
  function automatic logic [SET_LEN-1:0] calc_num_of_sets(input logic [REMAIN_BBOX_LEN-1:0] n);
    logic [REMAIN_BBOX_LEN:0] padded;
    padded = {1'b0, n} + (REMAIN_BBOX_LEN + 1)'(PE_NUM - 1);
    return SET_LEN'(padded / (REMAIN_BBOX_LEN + 1)'(PE_NUM));
  endfunction

endpackage

// File: rtl/oflow_core_pe_mask_gen.sv
// Thermometer encoder: the low min(count, PE_NUM) bits of mask are set.
module oflow_core_pe_mask_gen
  import oflow_core_define::*;
(
  input  logic [REMAIN_BBOX_LEN-1:0] count,
  output logic [PE_NUM-1:0]          mask
);

  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < PE_NUM; i++) begin
      mask[i] = (count > REMAIN_BBOX_LEN'(i));
    end
  end

endmodule

// File: rtl/oflow_core_fsm_top.sv
// Frame-level sequencer: splits a frame's bboxes into PE_NUM-sized sets and
// keeps at most one set in registration while the next set runs FE.
module oflow_core_fsm_top
  import oflow_core_define::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start_frame,
  input  logic [REMAIN_BBOX_LEN-1:0] num_of_bboxes_in,
  input  logic                       done_fe,
  input  logic                       done_registration,
  output logic                       start_pe,
  output logic                       new_set,
  output logic [SET_LEN-1:0]         num_of_sets,
  output logic [REMAIN_BBOX_LEN-1:0] counter_of_remain_bboxes,
  output logic [PE_NUM-1:0]          active_pe_mask,
  output logic                       busy,
  output logic                       done_frame
);

  oflow_core_top_state_t state_q, state_d;

  logic [SET_LEN-1:0]         num_of_sets_q, num_of_sets_d;
  logic [SET_LEN-1:0]         sets_issued_q, sets_issued_d;
  logic [SET_LEN-1:0]         fe_done_cnt_q, fe_done_cnt_d;
  logic [SET_LEN-1:0]         reg_done_cnt_q, reg_done_cnt_d;
  logic [SET_LEN-1:0]         reg_cnt_eff;
  logic [REMAIN_BBOX_LEN-1:0] remain_q, remain_d;
  logic                       reg_hit;
  logic                       launch_ok;

  always_comb begin
    // A registration pulse counts this cycle unless every issued set is already registered
    reg_hit     = done_registration && (state_q != StIdle) && (reg_done_cnt_q < sets_issued_q);
    reg_cnt_eff = reg_done_cnt_q + SET_LEN'(reg_hit);
    // reg_cnt_eff >= sets_issued - 1, written without underflow
    launch_ok   = ({1'b0, reg_cnt_eff} + (SET_LEN + 1)'(1)) >= {1'b0, sets_issued_q};

    state_d        = state_q;
    num_of_sets_d  = num_of_sets_q;
    sets_issued_d  = sets_issued_q;
    fe_done_cnt_d  = fe_done_cnt_q;
    reg_done_cnt_d = reg_cnt_eff;
    remain_d       = remain_q;

    unique case (state_q)
      StIdle: begin
        reg_done_cnt_d = '0;
        if (start_frame) begin
          num_of_sets_d = calc_num_of_sets(num_of_bboxes_in);
          if (num_of_bboxes_in != '0) begin
            remain_d = num_of_bboxes_in;
            state_d  = StStart;
          end else begin
            // Empty frame: zero sets, so WAIT_REG completes on the next cycle
            state_d = StWaitReg;
          end
        end
      end
      StStart:  state_d = StNewSet;
      StNewSet: state_d = StWaitFe;
      StWaitFe: begin
        if (done_fe) begin
          fe_done_cnt_d = fe_done_cnt_q + SET_LEN'(1);
          if (sets_issued_q == num_of_sets_q) begin
            state_d = StWaitReg;
          end else if (launch_ok) begin
            state_d = StNewSet;
          end else begin
            state_d = StHold;
          end
        end
      end
      StHold: begin
        if (launch_ok) state_d = StNewSet;
      end
      StWaitReg: begin
        if (reg_cnt_eff == num_of_sets_q) state_d = StDone;
      end
      StDone: begin
        state_d        = StIdle;
        remain_d       = '0;
        sets_issued_d  = '0;
        fe_done_cnt_d  = '0;
        reg_done_cnt_d = '0;
      end
      default: state_d = StIdle;
    endcase

    // Counter update lands with new_set so the mask always matches the set being launched
    if (state_d == StNewSet) begin
      sets_issued_d = sets_issued_q + SET_LEN'(1);
      if (state_q != StStart) begin
        remain_d = (remain_q > REMAIN_BBOX_LEN'(PE_NUM)) ?
                   remain_q - REMAIN_BBOX_LEN'(PE_NUM) : '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      num_of_sets_q  <= '0;
      sets_issued_q  <= '0;
      fe_done_cnt_q  <= '0;
      reg_done_cnt_q <= '0;
      remain_q       <= '0;
    end else begin
      state_q        <= state_d;
      num_of_sets_q  <= num_of_sets_d;
      sets_issued_q  <= sets_issued_d;
      fe_done_cnt_q  <= fe_done_cnt_d;
      reg_done_cnt_q <= reg_done_cnt_d;
      remain_q       <= remain_d;
    end
  end

  oflow_core_pe_mask_gen u_mask_gen (
    .count (remain_q),
    .mask  (active_pe_mask)
  );

  assign start_pe                 = (state_q == StStart);
  assign new_set                  = (state_q == StNewSet);
  assign done_frame               = (state_q == StDone);
  assign busy                     = (state_q != StIdle) && (state_q != StDone);
  assign num_of_sets              = num_of_sets_q;
  assign counter_of_remain_bboxes = remain_q;

endmodule
